// File: rtl/ai_spad_pkg.sv
// Shared types and helpers for the scratchpad responder.
package ai_spad_pkg;

  typedef enum logic [1:0] {IDLE, ACCESS, RESPOND} spad_state_t;

  localparam int          LANES     = 8;
  localparam logic [63:0] ERR_RDATA = 64'hDEAD_BEEF_DEAD_BEEF;

  // Byte enables moved up by 'lane'; enables pushed past lane 7 are dropped.
  function automatic logic [LANES-1:0] lane_shift_mask(input logic [LANES-1:0] wmask,
                                                       input logic [2:0]       lane);
    logic [2*LANES-1:0] wide;
    wide = {{LANES{1'b0}}, wmask} << lane;
    return wide[LANES-1:0];
  endfunction

endpackage

// File: rtl/ai_scratchpad_responder_bank.sv
// DEPTH x XLEN synchronous scratchpad: byte-enabled write, registered read.
module ai_spad_bank
  import ai_spad_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int DEPTH = 1024,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             we,
  input  logic [LANES-1:0] wmask,
  input  logic [AW-1:0]    waddr,
  input  logic [XLEN-1:0]  wdata,
  input  logic [AW-1:0]    raddr,
  output logic [XLEN-1:0]  rdata
);

  logic [XLEN-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < LANES; i++)
        if (wmask[i]) mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/ai_scratchpad_responder.sv
// Scratchpad responder: fixed-latency FSM, lane alignment, range check, abort.
// Optional perf counters are built when AI_SPAD_PERF_CNT_EN is defined.
module ai_scratchpad_responder
  import ai_spad_pkg::*;
#(
  parameter int              XLEN      = 64,
  parameter int              DEPTH     = 1024,
  parameter logic [XLEN-1:0] BASE_ADDR = 'h8000_0000,
  parameter int              LATENCY   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [XLEN-1:0]  mem_addr,
  input  logic [XLEN-1:0]  mem_wdata,
  input  logic [LANES-1:0] mem_wmask,
  input  logic             mem_req,
  input  logic             mem_we,
  input  logic             err_clr,
`ifdef AI_SPAD_PERF_CNT_EN
  input  logic             perf_clr,
  output logic [31:0]      perf_rd_cnt,
  output logic [31:0]      perf_wr_cnt,
  output logic [31:0]      perf_stall_cnt,
`endif
  output logic [XLEN-1:0]  mem_rdata,
  output logic             mem_ready,
  output logic             err
);

  localparam int             AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int             CW       = (LATENCY > 2) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0]  CNT_LOAD = CW'((LATENCY > 1) ? LATENCY - 2 : 0);

  spad_state_t      state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic             accept;
  logic [XLEN-1:0]  addr_q, wdata_q;
  logic [LANES-1:0] wmask_q;
  logic             we_q, oor_q;

  // Decode the live request in IDLE, the latched one afterwards.
  logic [XLEN-1:0]  cur_addr, word_off;
  logic             in_range;
  logic [AW-1:0]    idx;
  logic [2:0]       lane_q;
  logic [XLEN-1:0]  bank_q;

  assign cur_addr = (state == IDLE) ? mem_addr : addr_q;
  assign word_off = (cur_addr - BASE_ADDR) >> 3;
  assign in_range = (cur_addr >= BASE_ADDR) && (word_off < XLEN'(DEPTH));
  assign idx      = in_range ? word_off[AW-1:0] : '0;
  assign lane_q   = addr_q[2:0];

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    accept  = 1'b0;
    case (state)
      IDLE: if (mem_req) begin
        accept = 1'b1;
        if (LATENCY == 1) state_n = RESPOND;
        else begin
          state_n = ACCESS;
          cnt_n   = CNT_LOAD;
        end
      end
      ACCESS: begin
        if (!mem_req)      state_n = IDLE;
        else if (cnt == 0) state_n = RESPOND;
        else               cnt_n   = cnt - 1'b1;
      end
      RESPOND: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wmask_q   <= '0;
      we_q      <= 1'b0;
      oor_q     <= 1'b0;
      mem_ready <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      mem_ready <= (state_n == RESPOND);
      if (accept) begin
        addr_q  <= mem_addr;
        wdata_q <= mem_wdata;
        wmask_q <= mem_wmask;
        we_q    <= mem_we;
      end
      if (state_n == RESPOND) oor_q <= !in_range;
      // A new error outranks a simultaneous clear.
      if (state_n == RESPOND && !in_range) err <= 1'b1;
      else if (err_clr)                    err <= 1'b0;
    end
  end

  // Bank read is issued on the edge entering RESPOND; writes commit leaving it.
  ai_spad_bank #(.XLEN(XLEN), .DEPTH(DEPTH), .AW(AW)) u_bank (
    .clk   (clk),
    .we    ((state == RESPOND) && we_q && !oor_q),
    .wmask (lane_shift_mask(wmask_q, lane_q)),
    .waddr (idx),
    .wdata (wdata_q << {lane_q, 3'b000}),
    .raddr (idx),
    .rdata (bank_q)
  );

  always_comb begin
    mem_rdata = '0;
    if (mem_ready) mem_rdata = oor_q ? ERR_RDATA[XLEN-1:0] : (bank_q >> {lane_q, 3'b000});
  end

`ifdef AI_SPAD_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_rd_cnt    <= '0;
      perf_wr_cnt    <= '0;
      perf_stall_cnt <= '0;
    end else if (perf_clr) begin
      perf_rd_cnt    <= '0;
      perf_wr_cnt    <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (state == RESPOND && !we_q && !(&perf_rd_cnt)) perf_rd_cnt <= perf_rd_cnt + 1'b1;
      if (state == RESPOND &&  we_q && !(&perf_wr_cnt)) perf_wr_cnt <= perf_wr_cnt + 1'b1;
      if (mem_req && !mem_ready && !(&perf_stall_cnt))   perf_stall_cnt <= perf_stall_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_ai_scratchpad_responder.sv
// Randomized bench for ai_scratchpad_responder: LATENCY=1 and LATENCY=4 instances vs a byte-level model.
module tb_ai_scratchpad_responder;

  localparam int          DEPTH = 16;
  localparam logic [63:0] BASE  = 64'h8000_0000;
  localparam logic [63:0] ERRV  = 64'hDEAD_BEEF_DEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst_n   [2];
  logic [63:0] addr    [2];
  logic [63:0] wdata   [2];
  logic [7:0]  wmask   [2];
  logic        req     [2];
  logic        we      [2];
  logic        err_clr [2];
  logic [63:0] rdata   [2];
  logic        ready   [2];
  logic        err     [2];
`ifdef AI_SPAD_PERF_CNT_EN
  logic        perf_clr [2];
  logic [31:0] prd [2], pwr [2], pst [2];
`endif

  int checks = 0, failures = 0;
  logic [63:0] model_mem [2][DEPTH];
  bit          exp_err [2];

  always #5 clk = ~clk;

  ai_scratchpad_responder #(.XLEN(64), .DEPTH(DEPTH), .BASE_ADDR(BASE), .LATENCY(1)) u_l1 (
    .clk(clk), .rst_n(rst_n[0]), .mem_addr(addr[0]), .mem_wdata(wdata[0]), .mem_wmask(wmask[0]),
    .mem_req(req[0]), .mem_we(we[0]), .err_clr(err_clr[0]),
`ifdef AI_SPAD_PERF_CNT_EN
    .perf_clr(perf_clr[0]), .perf_rd_cnt(prd[0]), .perf_wr_cnt(pwr[0]), .perf_stall_cnt(pst[0]),
`endif
    .mem_rdata(rdata[0]), .mem_ready(ready[0]), .err(err[0]));

  ai_scratchpad_responder #(.XLEN(64), .DEPTH(DEPTH), .BASE_ADDR(BASE), .LATENCY(4)) u_l4 (
    .clk(clk), .rst_n(rst_n[1]), .mem_addr(addr[1]), .mem_wdata(wdata[1]), .mem_wmask(wmask[1]),
    .mem_req(req[1]), .mem_we(we[1]), .err_clr(err_clr[1]),
`ifdef AI_SPAD_PERF_CNT_EN
    .perf_clr(perf_clr[1]), .perf_rd_cnt(prd[1]), .perf_wr_cnt(pwr[1]), .perf_stall_cnt(pst[1]),
`endif
    .mem_rdata(rdata[1]), .mem_ready(ready[1]), .err(err[1]));

  function automatic int lat_of(int d);
    return (d == 0) ? 1 : 4;
  endfunction

  function automatic bit in_rng(logic [63:0] a);
    return (a >= BASE) && (((a - BASE) >> 3) < 64'(DEPTH));
  endfunction

  // Byte b of the response is byte (b+lane) of the stored word, or zero past the top.
  function automatic logic [63:0] exp_read(int d, logic [63:0] a);
    logic [63:0] word, r;
    int lane;
    if (!in_rng(a)) return ERRV;
    word = model_mem[d][int'((a - BASE) >> 3)];
    lane = int'(a[2:0]);
    r = '0;
    for (int b = 0; b < 8; b++)
      if (b + lane < 8) r[b*8 +: 8] = word[(b+lane)*8 +: 8];
    return r;
  endfunction

  task automatic model_write(int d, logic [63:0] a, logic [63:0] wd, logic [7:0] m);
    int lane, idx;
    if (!in_rng(a)) return;
    idx  = int'((a - BASE) >> 3);
    lane = int'(a[2:0]);
    for (int b = 0; b < 8; b++)
      if (b - lane >= 0 && m[b-lane]) model_mem[d][idx][b*8 +: 8] = wd[(b-lane)*8 +: 8];
  endtask

  // One full transaction; entered and left at a negedge with req low.
  task automatic do_txn(int d, bit w, logic [63:0] a, logic [63:0] wd, logic [7:0] m, bit clr);
    logic [63:0] exp_rd;
    bit ok, seen, e_rdy, e_after;
    int k;
    exp_rd  = w ? 64'h0 : exp_read(d, a);
    ok      = in_rng(a);
    e_rdy   = !ok ? 1'b1 : (clr ? 1'b0 : exp_err[d]);
    e_after = clr ? 1'b0 : e_rdy;
    addr[d] = a; wdata[d] = wd; wmask[d] = m; we[d] = w; req[d] = 1'b1; err_clr[d] = clr;
    k = 0; seen = 0;
    while (!seen && k < 20) begin
      @(posedge clk); k++;
      if (k == 1) begin
        #1;
        addr[d] = {$urandom, $urandom}; wdata[d] = {$urandom, $urandom};
        wmask[d] = 8'($urandom); we[d] = 1'($urandom);
      end
      @(negedge clk);
      if (ready[d]) seen = 1;
      else begin
        checks++;
        if (rdata[d] !== 64'h0) begin
          failures++; $display("FAIL idle_rdata d=%0d got=%h want=0", d, rdata[d]);
        end
      end
    end
    checks++;
    if (!seen || k != lat_of(d)) begin
      failures++; $display("FAIL latency d=%0d seen=%0d got=%0d want=%0d", d, seen, k, lat_of(d));
    end
    if (!w) begin
      checks++;
      if (rdata[d] !== exp_rd) begin
        failures++; $display("FAIL rdata d=%0d addr=%h got=%h want=%h", d, a, rdata[d], exp_rd);
      end
    end
    checks++;
    if (err[d] !== e_rdy) begin
      failures++; $display("FAIL err_at_ready d=%0d addr=%h got=%b want=%b", d, a, err[d], e_rdy);
    end
    if (w) model_write(d, a, wd, m);
    req[d] = 1'b0;
    @(negedge clk);
    err_clr[d] = 1'b0;
    exp_err[d] = e_after;
    checks++;
    if (ready[d] !== 1'b0 || rdata[d] !== 64'h0 || err[d] !== e_after) begin
      failures++;
      $display("FAIL post_pulse d=%0d ready=%b rdata=%h err=%b want 0/0/%b", d, ready[d], rdata[d], err[d], e_after);
    end
  endtask

  task automatic test_reset();
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0; req[d] = 0; we[d] = 0; err_clr[d] = 0;
      addr[d] = '0; wdata[d] = '0; wmask[d] = '0; exp_err[d] = 0;
`ifdef AI_SPAD_PERF_CNT_EN
      perf_clr[d] = 0;
`endif
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (ready[d] !== 1'b0 || rdata[d] !== 64'h0 || err[d] !== 1'b0) begin
        failures++; $display("FAIL reset d=%0d ready=%b rdata=%h err=%b want 0/0/0", d, ready[d], rdata[d], err[d]);
      end
      rst_n[d] = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic test_fill();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < DEPTH; i++)
        do_txn(d, 1'b1, BASE + 64'(i*8), {$urandom, $urandom}, 8'hFF, 1'b0);
  endtask

  task automatic test_basic_subword();
    for (int d = 0; d < 2; d++) begin
      do_txn(d, 1'b1, BASE, 64'h1122334455667788, 8'hFF, 1'b0);
      do_txn(d, 1'b0, BASE, '0, '0, 1'b0);
      do_txn(d, 1'b1, BASE + 4, 64'hCAFEF00D, 8'h0F, 1'b0);
      do_txn(d, 1'b0, BASE, '0, '0, 1'b0);
      do_txn(d, 1'b0, BASE + 4, '0, '0, 1'b0);
      checks++;
      if (model_mem[d][0] !== 64'hCAFEF00D55667788) begin
        failures++; $display("FAIL model_word0 d=%0d got=%h want=cafef00d55667788", d, model_mem[d][0]);
      end
    end
  endtask

  task automatic test_out_of_range();
    for (int d = 0; d < 2; d++) begin
      do_txn(d, 1'b0, BASE + 64'(8*DEPTH), '0, '0, 1'b0);
      err_clr[d] = 1'b1; @(negedge clk); err_clr[d] = 1'b0; exp_err[d] = 0;
      checks++;
      if (err[d] !== 1'b0) begin
        failures++; $display("FAIL err_clr d=%0d got=%b want=0", d, err[d]);
      end
      do_txn(d, 1'b1, BASE - 8, 64'h55, 8'hFF, 1'b0);
      do_txn(d, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8, '0, '0, 1'b1);
      do_txn(d, 1'b0, BASE + 64'(8*DEPTH - 1), '0, '0, 1'b0);
    end
  endtask

  task automatic test_abort();
    logic [63:0] a;
    bit any;
    a = BASE + 64'(8 * $urandom_range(DEPTH-1));
    addr[1] = a; wdata[1] = {$urandom, $urandom}; wmask[1] = 8'hFF; we[1] = 1'b1; req[1] = 1'b1;
    @(posedge clk); @(posedge clk);
    @(negedge clk); req[1] = 1'b0;
    any = 0;
    repeat (8) begin
      @(negedge clk);
      if (ready[1]) any = 1;
    end
    checks++;
    if (any) begin
      failures++; $display("FAIL abort_ready got=1 want=0");
    end
    do_txn(1, 1'b0, a, '0, '0, 1'b0);
  endtask

  task automatic test_random();
    logic [63:0] a;
    for (int n = 0; n < 40; n++)
      for (int d = 0; d < 2; d++) begin
        case ($urandom_range(9))
          0:       a = BASE - 64'($urandom_range(1, 64));
          1:       a = BASE + 64'(8*DEPTH) + 64'($urandom_range(255));
          default: a = BASE + 64'($urandom_range(8*DEPTH - 1));
        endcase
        do_txn(d, 1'($urandom), a, {$urandom, $urandom}, 8'($urandom), 1'b0);
      end
  endtask

  task automatic test_back_to_back();
    logic [63:0] al [3];
    int cyc, i, at [3];
    for (int d = 0; d < 2; d++) begin
      for (int j = 0; j < 3; j++) begin
        al[j] = BASE + 64'($urandom_range(8*DEPTH - 1)); at[j] = -1;
      end
      addr[d] = al[0]; we[d] = 1'b0; req[d] = 1'b1;
      cyc = 0; i = 0;
      while (i < 3 && cyc < 60) begin
        @(negedge clk); cyc++;
        if (ready[d]) begin
          at[i] = cyc;
          checks++;
          if (rdata[d] !== exp_read(d, al[i])) begin
            failures++; $display("FAIL b2b_rdata d=%0d n=%0d got=%h want=%h", d, i, rdata[d], exp_read(d, al[i]));
          end
          i++;
          if (i < 3) addr[d] = al[i]; else req[d] = 1'b0;
        end
      end
      req[d] = 1'b0;
      @(negedge clk);
      checks++;
      if (at[0] != lat_of(d) || at[1] - at[0] != lat_of(d) + 1 || at[2] - at[1] != lat_of(d) + 1) begin
        failures++; $display("FAIL b2b_spacing d=%0d at=%0d,%0d,%0d want step %0d", d, at[0], at[1], at[2], lat_of(d) + 1);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [63:0] a;
    a = BASE + 64'(8 * $urandom_range(DEPTH-1));
    addr[1] = a; wdata[1] = ~model_mem[1][int'((a - BASE) >> 3)]; wmask[1] = 8'hFF; we[1] = 1'b1; req[1] = 1'b1;
    @(posedge clk); @(posedge clk);
    @(negedge clk); rst_n[1] = 1'b0; req[1] = 1'b0;
    #1;
    checks++;
    if (ready[1] !== 1'b0 || err[1] !== 1'b0) begin
      failures++; $display("FAIL mid_reset ready=%b err=%b want 0/0", ready[1], err[1]);
    end
`ifdef AI_SPAD_PERF_CNT_EN
    checks++;
    if (prd[1] !== 0 || pwr[1] !== 0 || pst[1] !== 0) begin
      failures++; $display("FAIL perf_reset rd=%0d wr=%0d st=%0d want 0", prd[1], pwr[1], pst[1]);
    end
`endif
    @(negedge clk); rst_n[1] = 1'b1; exp_err[1] = 0;
    @(negedge clk);
    do_txn(1, 1'b0, a, '0, '0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_fill();
    test_basic_subword();
    test_out_of_range();
    test_abort();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
